// File: rtl/memblock_mo_pkg.sv
// Shared widths, tbus/size encodings, outstanding-entry layout and address helpers for memblock_mo.
package memblock_mo_pkg;

  localparam int unsigned PREG         = 7;
  localparam int unsigned ROB_SIZE_LOG = 6;
  localparam int unsigned TBUS_OPTYPE  = 2;

  localparam logic [TBUS_OPTYPE-1:0] TBUS_READ  = 2'd0;
  localparam logic [TBUS_OPTYPE-1:0] TBUS_WRITE = 2'd1;

  localparam logic [3:0] SIZE_B = 4'b0001;
  localparam logic [3:0] SIZE_H = 4'b0010;
  localparam logic [3:0] SIZE_W = 4'b0100;
  localparam logic [3:0] SIZE_D = 4'b1000;

  typedef struct packed {
    logic [PREG-1:0]         prd;
    logic                    robidx_flag;
    logic [ROB_SIZE_LOG-1:0] robidx;
    logic [3:0]              size;
    logic                    is_unsigned;
    logic [2:0]              offset;
    logic                    is_load;
    logic                    killed;
  } mo_entry_t;

  function automatic logic [63:0] agu(input logic [63:0] base, input logic [63:0] ofs);
    return base + ofs;
  endfunction

  // True when x is younger than the flushing instruction (ROB index with wrap flag).
  function automatic logic is_younger(input logic                    flush_flag,
                                      input logic [ROB_SIZE_LOG-1:0] flush_idx,
                                      input logic                    x_flag,
                                      input logic [ROB_SIZE_LOG-1:0] x_idx);
    return (flush_flag ^ x_flag) ^ (flush_idx < x_idx);
  endfunction

endpackage

// File: rtl/memblock_load_align.sv
// Extracts the addressed bytes from a 64-bit read beat and zero/sign-extends them.
module memblock_load_align
  import memblock_mo_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  offset_i,
  input  logic [3:0]  size_i,
  input  logic        is_unsigned_i,
  output logic [63:0] data_o
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (size_i)
      SIZE_B:  data_o = is_unsigned_i ? {56'b0, shifted[7:0]}
                                      : {{56{shifted[7]}}, shifted[7:0]};
      SIZE_H:  data_o = is_unsigned_i ? {48'b0, shifted[15:0]}
                                      : {{48{shifted[15]}}, shifted[15:0]};
      SIZE_W:  data_o = is_unsigned_i ? {32'b0, shifted[31:0]}
                                      : {{32{shifted[31]}}, shifted[31:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/memblock_mo.sv
// Memory-op issue block: tbus requests with an in-order outstanding queue, MMIO bypass and
// ROB-based flush of younger in-flight ops.
module memblock_mo
  import memblock_mo_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter logic [63:0] MMIO_LO = 64'h3000_0000,
  parameter logic [63:0] MMIO_HI = 64'h4070_0000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [PREG-1:0]         prd,
  input  logic                    is_load,
  input  logic                    is_store,
  input  logic                    is_unsigned,
  input  logic [63:0]             imm,
  input  logic [63:0]             src1,
  input  logic [63:0]             src2,
  input  logic [3:0]              ls_size,
  input  logic                    robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0] robidx,
  output logic                    tbus_index_valid,
  input  logic                    tbus_index_ready,
  output logic [63:0]             tbus_index,
  output logic [63:0]             tbus_write_data,
  output logic [63:0]             tbus_write_mask,
  output logic [TBUS_OPTYPE-1:0]  tbus_operation_type,
  input  logic [63:0]             tbus_read_data,
  input  logic                    tbus_operation_done,
  output logic                    out_instr_valid,
  output logic                    out_need_to_wb,
  output logic                    out_mmio,
  output logic [PREG-1:0]         out_prd,
  output logic                    out_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] out_robidx,
  output logic [63:0]             opload_read_data_wb,
  output logic                    mem_stall,
  input  logic                    flush_valid,
  input  logic                    flush_robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0] flush_robidx,
  output logic                    memblock2dcache_flush
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  logic [PtrW-1:0] wptr_q, rptr_q, count;
  mo_entry_t       entry_q [DEPTH];
  mo_entry_t       head, new_entry;
  logic [DEPTH-1:0] entry_valid, kill_vec;
  logic [63:0]     addr, size_mask, load_data;
  logic            is_mmio, is_mem_op, full, empty, mmio_hold, in_flushed;
  logic            enq, deq, mmio_accept;

  logic                    mmio_valid_q, mmio_wb_q, mmio_flag_q;
  logic [PREG-1:0]         mmio_prd_q;
  logic [ROB_SIZE_LOG-1:0] mmio_robidx_q;

  assign addr        = agu(src1, imm);
  assign is_mmio     = (addr >= MMIO_LO) && (addr <= MMIO_HI);
  assign is_mem_op   = instr_valid & (is_load | is_store);
  assign full        = (wptr_q[IdxW-1:0] == rptr_q[IdxW-1:0]) && (wptr_q[IdxW] != rptr_q[IdxW]);
  assign empty       = (wptr_q == rptr_q);
  assign count       = wptr_q - rptr_q;
  assign head        = entry_q[rptr_q[IdxW-1:0]];
  assign in_flushed  = flush_valid & is_younger(flush_robidx_flag, flush_robidx, robidx_flag, robidx);
  assign mmio_hold   = is_mem_op & is_mmio & ~empty;
  assign instr_ready = ~full & ~mmio_hold;
  assign mem_stall   = ~instr_ready;

  assign tbus_index_valid = is_mem_op & ~is_mmio & instr_ready & ~in_flushed;
  assign enq              = tbus_index_valid & tbus_index_ready;
  // MMIO ops must wait until every earlier tbus op has drained.
  assign mmio_accept      = is_mem_op & is_mmio & empty & ~in_flushed;
  assign deq              = tbus_operation_done & ~empty;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = {1'b0, IdxW'(i) - rptr_q[IdxW-1:0]} < count;
      kill_vec[i]    = flush_valid & entry_valid[i] &
                       is_younger(flush_robidx_flag, flush_robidx,
                                  entry_q[i].robidx_flag, entry_q[i].robidx);
    end
  end

  assign memblock2dcache_flush = (instr_valid & in_flushed) | (|kill_vec);

  always_comb begin
    case (ls_size)
      SIZE_B:  size_mask = 64'hFF;
      SIZE_H:  size_mask = 64'hFFFF;
      SIZE_W:  size_mask = 64'hFFFF_FFFF;
      default: size_mask = '1;
    endcase
  end

  always_comb begin
    tbus_index          = '0;
    tbus_write_mask     = '0;
    tbus_write_data     = '0;
    tbus_operation_type = TBUS_READ;
    if (tbus_index_valid) begin
      tbus_index = addr;
      if (is_store) begin
        tbus_operation_type = TBUS_WRITE;
        tbus_write_mask     = (ls_size == SIZE_D) ? '1 : (size_mask << {addr[2:0], 3'b000});
        tbus_write_data     = src2 << {addr[2:0], 3'b000};
      end
    end
  end

  always_comb begin
    new_entry             = '0;
    new_entry.prd         = prd;
    new_entry.robidx_flag = robidx_flag;
    new_entry.robidx      = robidx;
    new_entry.size        = ls_size;
    new_entry.is_unsigned = is_unsigned;
    new_entry.offset      = addr[2:0];
    new_entry.is_load     = is_load;
  end

  memblock_load_align u_load_align (
    .rdata_i      (tbus_read_data),
    .offset_i     (head.offset),
    .size_i       (head.size),
    .is_unsigned_i(head.is_unsigned),
    .data_o       (load_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      mmio_valid_q  <= 1'b0;
      mmio_wb_q     <= 1'b0;
      mmio_flag_q   <= 1'b0;
      mmio_prd_q    <= '0;
      mmio_robidx_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_vec[i]) entry_q[i].killed <= 1'b1;
      end
      if (enq) begin
        entry_q[wptr_q[IdxW-1:0]] <= new_entry;
        wptr_q                    <= wptr_q + 1'b1;
      end
      if (deq) rptr_q <= rptr_q + 1'b1;
      mmio_valid_q  <= mmio_accept;
      mmio_wb_q     <= mmio_accept & is_load;
      mmio_flag_q   <= mmio_accept & robidx_flag;
      mmio_prd_q    <= mmio_accept ? prd : '0;
      mmio_robidx_q <= mmio_accept ? robidx : '0;
    end
  end

  always_comb begin
    out_instr_valid     = 1'b0;
    out_need_to_wb      = 1'b0;
    out_mmio            = 1'b0;
    out_prd             = '0;
    out_robidx_flag     = 1'b0;
    out_robidx          = '0;
    opload_read_data_wb = '0;
    if (mmio_valid_q) begin
      out_instr_valid = 1'b1;
      out_mmio        = 1'b1;
      out_need_to_wb  = mmio_wb_q;
      out_prd         = mmio_prd_q;
      out_robidx_flag = mmio_flag_q;
      out_robidx      = mmio_robidx_q;
    end else if (deq && !head.killed) begin
      out_instr_valid     = 1'b1;
      out_need_to_wb      = head.is_load;
      out_prd             = head.prd;
      out_robidx_flag     = head.robidx_flag;
      out_robidx          = head.robidx;
      opload_read_data_wb = load_data;
    end
  end

endmodule

// File: tb/tb_memblock_mo.sv
// Directed self-checking bench for memblock_mo.
module tb_memblock_mo;
  import memblock_mo_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        instr_valid, instr_ready;
  logic [6:0]  prd;
  logic        is_load, is_store, is_unsigned;
  logic [63:0] imm, src1, src2;
  logic [3:0]  ls_size;
  logic        robidx_flag;
  logic [5:0]  robidx;
  logic        tbus_index_valid, tbus_index_ready;
  logic [63:0] tbus_index, tbus_write_data, tbus_write_mask, tbus_read_data;
  logic [1:0]  tbus_operation_type;
  logic        tbus_operation_done;
  logic        out_instr_valid, out_need_to_wb, out_mmio, out_robidx_flag;
  logic [6:0]  out_prd;
  logic [5:0]  out_robidx;
  logic [63:0] opload_read_data_wb;
  logic        mem_stall;
  logic        flush_valid, flush_robidx_flag;
  logic [5:0]  flush_robidx;
  logic        memblock2dcache_flush;

  int checks = 0;
  int errors = 0;

  memblock_mo dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .instr_valid          (instr_valid),
    .instr_ready          (instr_ready),
    .prd                  (prd),
    .is_load              (is_load),
    .is_store             (is_store),
    .is_unsigned          (is_unsigned),
    .imm                  (imm),
    .src1                 (src1),
    .src2                 (src2),
    .ls_size              (ls_size),
    .robidx_flag          (robidx_flag),
    .robidx               (robidx),
    .tbus_index_valid     (tbus_index_valid),
    .tbus_index_ready     (tbus_index_ready),
    .tbus_index           (tbus_index),
    .tbus_write_data      (tbus_write_data),
    .tbus_write_mask      (tbus_write_mask),
    .tbus_operation_type  (tbus_operation_type),
    .tbus_read_data       (tbus_read_data),
    .tbus_operation_done  (tbus_operation_done),
    .out_instr_valid      (out_instr_valid),
    .out_need_to_wb       (out_need_to_wb),
    .out_mmio             (out_mmio),
    .out_prd              (out_prd),
    .out_robidx_flag      (out_robidx_flag),
    .out_robidx           (out_robidx),
    .opload_read_data_wb  (opload_read_data_wb),
    .mem_stall            (mem_stall),
    .flush_valid          (flush_valid),
    .flush_robidx_flag    (flush_robidx_flag),
    .flush_robidx         (flush_robidx),
    .memblock2dcache_flush(memblock2dcache_flush)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input logic ld, input logic [63:0] base, input logic [63:0] ofs,
                    input logic [3:0] sz, input logic uns, input logic [6:0] p,
                    input logic [5:0] rob, input logic [63:0] wdata);
    instr_valid = 1'b1;
    is_load     = ld;
    is_store    = ~ld;
    src1        = base;
    imm         = ofs;
    ls_size     = sz;
    is_unsigned = uns;
    prd         = p;
    robidx      = rob;
    robidx_flag = 1'b0;
    src2        = wdata;
  endtask

  initial begin
    reset_n = 1'b0;
    instr_valid = 0; is_load = 0; is_store = 0; is_unsigned = 0;
    prd = '0; imm = '0; src1 = '0; src2 = '0; ls_size = SIZE_D;
    robidx_flag = 0; robidx = '0; tbus_index_ready = 1'b1;
    tbus_read_data = '0; tbus_operation_done = 0;
    flush_valid = 0; flush_robidx_flag = 0; flush_robidx = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_stall", mem_stall, 0);
    chk("rst_tvalid", tbus_index_valid, 0);
    chk("rst_outv", out_instr_valid, 0);
    chk("rst_dflush", memblock2dcache_flush, 0);

    // Fill the queue with four loads, fifth is refused.
    for (int i = 0; i < 4; i++) begin
      tick();
      op(1, 64'h8000_0000 + 64'(8 * i), 0, SIZE_D, 0, 7'(10 + i), 6'(i), 0);
      #1;
      chk("fill_tvalid", tbus_index_valid, 1);
      chk("fill_index", tbus_index, 64'h8000_0000 + 64'(8 * i));
    end
    tick();
    op(1, 64'h8000_0020, 0, SIZE_D, 0, 7'd14, 6'd4, 0);
    #1;
    chk("full_ready", instr_ready, 0);
    chk("full_stall", mem_stall, 1);
    chk("full_tvalid", tbus_index_valid, 0);
    instr_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tbus_operation_done = 1;
      tbus_read_data = 64'h1111 * 64'(i + 1);
      #1;
      chk("drain_outv", out_instr_valid, 1);
      chk("drain_prd", out_prd, 64'(10 + i));
      chk("drain_wb", out_need_to_wb, 1);
      chk("drain_data", opload_read_data_wb, 64'h1111 * 64'(i + 1));
    end
    tick();
    tbus_operation_done = 0;
    #1;
    chk("drained_ready", instr_ready, 1);
    tbus_operation_done = 1;
    #1;
    chk("stray_done", out_instr_valid, 0);

    // Signed byte load and unsigned halfword load.
    tick();
    tbus_operation_done = 0;
    op(1, 64'h8000_0000, 3, SIZE_B, 0, 7'd20, 6'd9, 0);
    #1;
    chk("lb_index", tbus_index, 64'h8000_0003);
    chk("lb_optype", tbus_operation_type, 0);
    chk("lb_mask", tbus_write_mask, 0);
    tick();
    instr_valid = 0;
    tbus_operation_done = 1;
    tbus_read_data = 64'h0000_0000_80FF_0000;
    #1;
    chk("lb_data", opload_read_data_wb, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_prd", out_prd, 20);
    tick();
    tbus_operation_done = 0;
    op(1, 64'h8000_0000, 2, SIZE_H, 1, 7'd21, 6'd10, 0);
    tick();
    instr_valid = 0;
    tbus_operation_done = 1;
    #1;
    chk("lhu_data", opload_read_data_wb, 64'h80FF);

    // Halfword store at offset 6.
    tick();
    tbus_operation_done = 0;
    op(0, 64'h8000_0000, 6, SIZE_H, 0, 7'd22, 6'd11, 64'hBEEF);
    #1;
    chk("sh_mask", tbus_write_mask, 64'hFFFF_0000_0000_0000);
    chk("sh_data", tbus_write_data, 64'hBEEF_0000_0000_0000);
    chk("sh_optype", tbus_operation_type, 1);
    tick();
    instr_valid = 0;
    tbus_operation_done = 1;
    #1;
    chk("sh_outv", out_instr_valid, 1);
    chk("sh_wb", out_need_to_wb, 0);
    chk("sh_rob", out_robidx, 11);

    // Flush: entries robidx 2,3,4; flush at 5 kills none, flush at 2 kills 3 and 4.
    tick();
    tbus_operation_done = 0;
    for (int r = 2; r <= 4; r++) begin
      op(1, 64'h8000_0000, 0, SIZE_D, 0, 7'(30 + r), 6'(r), 0);
      tick();
    end
    instr_valid = 0;
    flush_valid = 1;
    flush_robidx = 6'd5;
    #1;
    chk("flush_old_none", memblock2dcache_flush, 0);
    tick();
    flush_robidx = 6'd2;
    op(1, 64'h8000_0000, 0, SIZE_D, 0, 7'd36, 6'd6, 0);
    #1;
    chk("flush_dflush", memblock2dcache_flush, 1);
    chk("flush_in_block", tbus_index_valid, 0);
    tick();
    instr_valid = 0;
    flush_valid = 0;
    for (int k = 0; k < 3; k++) begin
      tbus_operation_done = 1;
      #1;
      chk("flush_outv", out_instr_valid, 64'(k == 0));
      if (k == 0) chk("flush_rob", out_robidx, 2);
      tick();
    end
    #1;
    chk("flush_no_extra", out_instr_valid, 0);
    tick();
    tbus_operation_done = 0;

    // MMIO load waits for one outstanding entry.
    op(1, 64'h8000_0000, 0, SIZE_D, 0, 7'd32, 6'd7, 0);
    tick();
    op(1, 64'h3000_0000, 0, SIZE_D, 0, 7'd33, 6'd8, 0);
    tbus_read_data = 64'hDEAD_BEEF;
    #1;
    chk("mmio_hold_ready", instr_ready, 0);
    chk("mmio_tvalid", tbus_index_valid, 0);
    tick();
    chk("mmio_hold2", instr_ready, 0);
    tbus_operation_done = 1;
    #1;
    chk("mmio_prev_outv", out_instr_valid, 1);
    chk("mmio_prev_prd", out_prd, 32);
    chk("mmio_prev_mmio", out_mmio, 0);
    tick();
    tbus_operation_done = 0;
    #1;
    chk("mmio_ready", instr_ready, 1);
    chk("mmio_no_tbus", tbus_index_valid, 0);
    tick();
    instr_valid = 0;
    #1;
    chk("mmio_out", out_mmio, 1);
    chk("mmio_outv", out_instr_valid, 1);
    chk("mmio_wb", out_need_to_wb, 1);
    chk("mmio_prd", out_prd, 33);
    chk("mmio_rob", out_robidx, 8);
    chk("mmio_data", opload_read_data_wb, 0);
    tick();
    chk("mmio_out_clr", out_mmio, 0);

    // Full queue with done and new op in the same cycle.
    for (int i = 0; i < 4; i++) begin
      op(1, 64'h8000_0000 + 64'(8 * i), 0, SIZE_D, 0, 7'(40 + i), 6'(12 + i), 0);
      tick();
    end
    op(1, 64'h8000_0040, 0, SIZE_D, 0, 7'd50, 6'd16, 0);
    tbus_operation_done = 1;
    #1;
    chk("fd_ready", instr_ready, 0);
    chk("fd_tvalid", tbus_index_valid, 0);
    chk("fd_prd", out_prd, 40);
    tick();
    tbus_operation_done = 0;
    #1;
    chk("fd_ready2", instr_ready, 1);
    chk("fd_tvalid2", tbus_index_valid, 1);
    tick();
    instr_valid = 0;
    for (int k = 0; k < 4; k++) begin
      tbus_operation_done = 1;
      #1;
      chk("fd_order", out_prd, (k < 3) ? 64'(41 + k) : 64'd50);
      tick();
    end
    tbus_operation_done = 0;

    // Reset with two entries outstanding.
    op(1, 64'h8000_0000, 0, SIZE_D, 0, 7'd60, 6'd20, 0);
    tick();
    op(1, 64'h8000_0008, 0, SIZE_D, 0, 7'd61, 6'd21, 0);
    tick();
    instr_valid = 0;
    #2 reset_n = 0;
    #1;
    chk("mid_rst_ready", instr_ready, 1);
    chk("mid_rst_outv", out_instr_valid, 0);
    #1 reset_n = 1;
    tick();
    tbus_operation_done = 1;
    #1;
    chk("post_rst_stray", out_instr_valid, 0);
    tick();
    tbus_operation_done = 0;
    op(1, 64'h8000_0000, 0, SIZE_D, 0, 7'd62, 6'd22, 0);
    tick();
    instr_valid = 0;
    tbus_operation_done = 1;
    #1;
    chk("post_rst_outv", out_instr_valid, 1);
    chk("post_rst_prd", out_prd, 62);
    tick();
    tbus_operation_done = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
